// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C request arbiter: FSM states, control-word
// bit positions and response error codes.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } arb_state_t;

  localparam int CTRL_START   = 31;
  localparam int CTRL_PAGE    = 17;
  localparam int CTRL_RAND    = 16;
  localparam int CTRL_MEM_MSB = 15;
  localparam int CTRL_MEM_LSB = 8;
  localparam int CTRL_DEV_MSB = 7;
  localparam int CTRL_DEV_LSB = 0;

  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  // Address byte on the bus; the R/W bit is always 0, reads use random-read mode.
  function automatic logic [7:0] dev_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ. The pointer register lives in the parent.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               gnt_any
);

  logic [PW-1:0] k;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = PW'(wrap_idx(int'(rr_ptr), i));
      if (!gnt_any && req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
        gnt[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant,
// START sequencing against master idle, timeouts and response return.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int START_TO = 1024,
  parameter int TXN_TO   = 2000000
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*7-1:0] req_dev_addr,
  input  logic [NUM_REQ*8-1:0] req_mem_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 arb_busy,
  output logic [31:0]          i2c_ctrl,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  input  logic                 i2c_master_idle
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (START_TO > TXN_TO) ? START_TO : TXN_TO;
  localparam int TW   = $clog2(TMAX) + 1;

  arb_state_t    state;
  logic [PW-1:0] rr_ptr, gnt_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic          gnt_any;
  logic [TW-1:0] timer, timer_inc;
  logic          rw_q, err_q;
  logic [6:0]    dev_q;
  logic [7:0]    mem_q, wbyte_q, rbyte_q;
  logic          unused_rdata_hi;

  assign unused_rdata_hi = ^rdata[31:8];

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  // Saturating so a stuck master can never wrap the timer back to a legal count.
  assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      timer   <= '0;
      rw_q    <= 1'b0;
      err_q   <= RSP_OK;
      dev_q   <= '0;
      mem_q   <= '0;
      wbyte_q <= '0;
      rbyte_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            gnt_q   <= gnt_idx;
            rw_q    <= req_rw[gnt_idx];
            dev_q   <= req_dev_addr[7*int'(gnt_idx) +: 7];
            mem_q   <= req_mem_addr[8*int'(gnt_idx) +: 8];
            wbyte_q <= req_wdata[8*int'(gnt_idx) +: 8];
            rbyte_q <= '0;
            err_q   <= RSP_OK;
            timer   <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i2c_master_idle) begin
            timer <= '0;
            state <= ST_RUN;
          end else if (timer == TW'(START_TO - 1)) begin
            err_q <= RSP_TIMEOUT;
            state <= ST_RESP;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_RUN: begin
          if (i2c_master_idle) begin
            rbyte_q <= rw_q ? rdata[7:0] : 8'h00;
            state   <= ST_RESP;
          end else if (timer == TW'(TXN_TO - 1)) begin
            err_q <= RSP_TIMEOUT;
            state <= ST_RECOVER;
          end else begin
            timer <= timer_inc;
          end
        end
        // No timeout here: the master must finish its own abort before reuse.
        ST_RECOVER: begin
          if (i2c_master_idle) state <= ST_RESP;
        end
        ST_RESP: begin
          rr_ptr <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE && !s_axi_areset) ? gnt : '0;
  assign arb_busy  = (state != ST_IDLE);

  always_comb begin
    i2c_ctrl = '0;
    if (state == ST_ISSUE || state == ST_RUN || state == ST_RECOVER) begin
      i2c_ctrl[CTRL_START]                 = (state == ST_ISSUE);
      i2c_ctrl[CTRL_RAND]                  = rw_q;
      i2c_ctrl[CTRL_MEM_MSB:CTRL_MEM_LSB]  = mem_q;
      i2c_ctrl[CTRL_DEV_MSB:CTRL_DEV_LSB]  = dev_byte(dev_q);
    end
  end

  assign wdata     = {24'h0, wbyte_q};
  assign rsp_valid = (state == ST_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q) : '0;
  assign rsp_rdata = (state == ST_RESP) ? rbyte_q : 8'h00;
  assign rsp_err   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter with a small I2C master idle model.
module tb_i2c_req_arbiter;

  localparam int N   = 2;
  localparam int STO = 16;
  localparam int TTO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v[N];
  logic       rwv[N];
  logic [6:0] devv[N];
  logic [7:0] memv[N];
  logic [7:0] wdv[N];

  logic [N-1:0]   req_valid, req_ready, req_rw, rsp_valid;
  logic [N*7-1:0] req_dev_addr;
  logic [N*8-1:0] req_mem_addr, req_wdata;
  logic [7:0]     rsp_rdata, mrd;
  logic           rsp_err, arb_busy, idle;
  logic [31:0]    i2c_ctrl, wdata, rdata;
  int             mmode;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_valid[g]          = v[g];
    assign req_rw[g]             = rwv[g];
    assign req_dev_addr[7*g +: 7] = devv[g];
    assign req_mem_addr[8*g +: 8] = memv[g];
    assign req_wdata[8*g +: 8]    = wdv[g];
  end
  assign rdata = {24'hABCDEF, mrd};

  i2c_req_arbiter #(.NUM_REQ(N), .START_TO(STO), .TXN_TO(TTO)) dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_dev_addr    (req_dev_addr),
    .req_mem_addr    (req_mem_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .arb_busy        (arb_busy),
    .i2c_ctrl        (i2c_ctrl),
    .wdata           (wdata),
    .rdata           (rdata),
    .i2c_master_idle (idle)
  );

  typedef struct {
    int         idx;
    logic [7:0] rd;
    logic       err;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [63:0] ctrl_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input int i, input logic [31:0] ctrl, input logic [31:0] wd,
                            input logic [7:0] rd, input logic err, input bit with_rsp);
    rsp_t e;
    ctrl_q.push_back({ctrl, wd});
    if (with_rsp) begin
      e.idx = i; e.rd = rd; e.err = err;
      rsp_q.push_back(e);
    end
  endtask

  task automatic send(input int i, input logic rw, input logic [6:0] dev,
                      input logic [7:0] mem, input logic [7:0] wd);
    bit ok;
    ok = 0;
    rwv[i] = rw; devv[i] = dev; memv[i] = mem; wdv[i] = wd; v[i] = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; break; end
    end
    check("accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1 v[i] = 1'b0;
    @(negedge clk);
    check("start_latency", {31'b0, i2c_ctrl[31]}, 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && !arb_busy) begin ok = 1; break; end
    end
    check("done", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Master model: drop idle 3 cycles after START, hold low 20 (or 100 when long).
  initial begin
    idle = 1'b1;
    forever begin
      @(negedge clk);
      if (i2c_ctrl[31]) begin
        if (mmode != 1) begin
          repeat (3) @(posedge clk);
          #1 idle = 1'b0;
          repeat ((mmode == 2) ? 100 : 20) @(posedge clk);
          #1 idle = 1'b1;
        end
        while (i2c_ctrl[31]) @(negedge clk);
      end
    end
  end

  // Monitor: grants, START words and responses against the expectation queues.
  initial begin
    logic        prev_start;
    logic [31:0] prev_ctrl;
    logic [63:0] ec;
    rsp_t        e;
    int          idle_run;
    prev_start = 1'b0; prev_ctrl = '0; idle_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0)
          check("grant_onehot", {31'b0, $onehot(req_ready) && !arb_busy}, 32'd1);
        if (i2c_ctrl[31] && !prev_start) begin
          if (ctrl_q.size() == 0) check("unexpected_start", i2c_ctrl, 32'h0);
          else begin
            ec = ctrl_q.pop_front();
            check("ctrl_word", i2c_ctrl, ec[63:32]);
            check("wdata", wdata, ec[31:0]);
          end
        end
        if (prev_start && !i2c_ctrl[31] && rsp_valid == '0)
          check("start_drop_hold", i2c_ctrl, prev_ctrl & 32'h7FFF_FFFF);
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) check("unexpected_rsp", {30'b0, rsp_valid}, 32'h0);
          else begin
            e = rsp_q.pop_front();
            check("rsp_valid", {30'b0, rsp_valid}, {30'b0, N'(1) << e.idx});
            check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e.rd});
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            check("rsp_ctrl_zero", i2c_ctrl, 32'h0);
            check("rsp_latency", {31'b0, e.err ? (idle_run >= 1) : (idle_run == 1)}, 32'd1);
          end
        end
      end
      prev_start = i2c_ctrl[31];
      prev_ctrl  = i2c_ctrl;
      idle_run   = idle ? idle_run + 1 : 0;
    end
  end

  initial begin
    int cnt;
    bit seen;
    mmode = 0; mrd = 8'h3C;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; rwv[i] = 1'b0; devv[i] = '0; memv[i] = '0; wdv[i] = '0;
    end

    // Write on req0 and random read on req1, both pending out of reset.
    expect_txn(0, 32'h8000_12A0, 32'h0000_00A5, 8'h00, 1'b0, 1);
    expect_txn(1, 32'h8001_40A0, 32'h0000_0000, 8'h3C, 1'b0, 1);
    fork
      send(0, 1'b0, 7'h50, 8'h12, 8'hA5);
      send(1, 1'b1, 7'h50, 8'h40, 8'h00);
      begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", {30'b0, req_ready}, 32'h0);
        check("rst_ctrl", i2c_ctrl, 32'h0);
        check("rst_busy", {31'b0, arb_busy}, 32'h0);
        check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    wait_done();

    // Second simultaneous pair: req0 again wins.
    expect_txn(0, 32'h8000_21A4, 32'h0000_005A, 8'h00, 1'b0, 1);
    expect_txn(1, 32'h8001_33AE, 32'h0000_0099, 8'h3C, 1'b0, 1);
    fork
      send(0, 1'b0, 7'h52, 8'h21, 8'h5A);
      send(1, 1'b1, 7'h57, 8'h33, 8'h99);
    join
    wait_done();

    // START timeout: master never leaves idle.
    mmode = 1; mrd = 8'h55;
    expect_txn(1, 32'h8000_05A0, 32'h0000_0011, 8'h00, 1'b1, 1);
    send(1, 1'b0, 7'h50, 8'h05, 8'h11);
    cnt = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (i2c_ctrl[31]) cnt++;
      else break;
    end
    check("start_width", cnt, STO);
    wait_done();
    mmode = 0;

    // Transaction timeout then recovery; req1 waits through RECOVER.
    mmode = 2;
    expect_txn(0, 32'h8001_80A0, 32'h0000_0000, 8'h00, 1'b1, 1);
    send(0, 1'b1, 7'h50, 8'h80, 8'h00);
    repeat (75) @(negedge clk);
    check("recover_busy", {31'b0, arb_busy}, 32'd1);
    check("recover_ctrl", i2c_ctrl, 32'h0001_80A0);
    check("recover_no_rsp", rsp_q.size(), 32'd1);
    @(posedge clk); #1 mmode = 0;
    expect_txn(1, 32'h8001_81A0, 32'h0000_0000, 8'h55, 1'b0, 1);
    send(1, 1'b1, 7'h50, 8'h81, 8'h00);
    wait_done();

    // Plain write on req0 leaves the pointer at 1.
    expect_txn(0, 32'h8000_12A0, 32'h0000_00A5, 8'h00, 1'b0, 1);
    send(0, 1'b0, 7'h50, 8'h12, 8'hA5);
    wait_done();

    // Reset in the middle of RUN.
    expect_txn(1, 32'h8000_60A0, 32'h0000_0077, 8'h00, 1'b0, 0);
    send(1, 1'b0, 7'h50, 8'h60, 8'h77);
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!idle) begin seen = 1; break; end
    end
    check("run_reached", {31'b0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ctrl", i2c_ctrl, 32'h0);
    check("midrst_busy", {31'b0, arb_busy}, 32'h0);
    check("midrst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("midrst_wdata", wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (idle) begin seen = 1; break; end
    end
    check("idle_back", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    expect_txn(0, 32'h8000_01A0, 32'h0000_0001, 8'h00, 1'b0, 1);
    expect_txn(1, 32'h8001_02A2, 32'h0000_0000, 8'h55, 1'b0, 1);
    fork
      send(0, 1'b0, 7'h50, 8'h01, 8'h01);
      send(1, 1'b1, 7'h51, 8'h02, 8'h00);
    join
    wait_done();

    check("ctrl_q_empty", ctrl_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
